ls_mem_responder: RTL

//  Memory-side responder for the CPU load/store path. Accepts LOAD/STOR requests from the control FSM over a valid/ready handshake.

---
 rtl/ls_mem_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ls_mem_responder.sv
// Load/store responder on an internal word RAM plus an always-on registered fetch port.
// Optional macro ADDR_CHECK_EN: flag/suppress LS accesses at or above DEPTH and zero out-of-range fetches.
module ls_mem_responder #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_data
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_RSP} state_e;

   state_e            state_q, state_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [DATA_W-1:0] if_data_q, if_data_d;
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              mem_we_c, mem_rd_c;
   logic              req_ok_c, if_ok_c;
   logic [IDX_W-1:0]  req_idx_c, if_idx_c;

   // Out-of-range addresses wrap onto the implemented words.
   assign req_idx_c = IDX_W'(32'(req_addr) % DEPTH);
   assign if_idx_c  = IDX_W'(32'(if_addr) % DEPTH);

`ifdef ADDR_CHECK_EN
   logic rsp_err_q, rsp_err_d;
   logic ld_err_q, ld_err_d;

   assign req_ok_c = (32'(req_addr) < DEPTH);
   assign if_ok_c  = (32'(if_addr) < DEPTH);
   assign rsp_err  = rsp_err_q;
`else
   assign req_ok_c = 1'b1;
   assign if_ok_c  = 1'b1;
   assign rsp_err  = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      mem_we_c    = 1'b0;
      mem_rd_c    = 1'b0;
`ifdef ADDR_CHECK_EN
      rsp_err_d   = rsp_err_q;
      ld_err_d    = ld_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               if (req_we) begin
                  mem_we_c    = req_ok_c;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = '0;
                  state_d     = S_RSP;
`ifdef ADDR_CHECK_EN
                  rsp_err_d   = ~req_ok_c;
`endif
               end else begin
                  mem_rd_c = 1'b1;
                  state_d  = S_RD;
`ifdef ADDR_CHECK_EN
                  ld_err_d = ~req_ok_c;
`endif
               end
            end
         end
         S_RD: begin
            rsp_valid_d = 1'b1;
            state_d     = S_RSP;
`ifdef ADDR_CHECK_EN
            rsp_data_d  = ld_err_q ? '0 : rd_data_q;
            rsp_err_d   = ld_err_q;
`else
            rsp_data_d  = rd_data_q;
`endif
         end
         S_RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
`ifdef ADDR_CHECK_EN
               rsp_err_d   = 1'b0;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase

      req_ready_d = (state_d == S_IDLE);

      // Fetch sees a same-edge store to its address (new word forwarded).
      if (!if_ok_c) begin
         if_data_d = '0;
      end else if (mem_we_c && (if_idx_c == req_idx_c)) begin
         if_data_d = req_wdata;
      end else begin
         if_data_d = mem[if_idx_c];
      end
   end

   // RAM array and its registered LS read port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem[req_idx_c] <= req_wdata;
      end
      if (mem_rd_c) begin
         rd_data_q <= mem[req_idx_c];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         if_data_q   <= '0;
`ifdef ADDR_CHECK_EN
         rsp_err_q   <= 1'b0;
         ld_err_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         if_data_q   <= if_data_d;
`ifdef ADDR_CHECK_EN
         rsp_err_q   <= rsp_err_d;
         ld_err_q    <= ld_err_d;
`endif
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign if_data   = if_data_q;

endmodule
